f1_start_ctrl: RTL

- Controller that sequences an F1 start-light gantry and times a driver's reaction.
- Contains its own tick prescaler; on trigger it lights 8 lamps one per tick, holds all lamps on for a pseudo-random number of ticks, then extinguishes them.
- Counts clock cycles until the react input asserts, and flags jump starts.
- Sits between the board buttons and the 8-bit light bar.

---
 rtl/f1_start_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/f1_start_ctrl.sv
// f1_start_ctrl: F1 start-light gantry sequencer with reaction timer.
//
// After a trigger, the 8 lamps light one per prescaler tick, stay fully lit
// for a pseudo-random number of ticks, then go dark. Reaction time is counted
// in clk cycles from lights-out until the react button is pressed. Pressing
// react while lamps are still lighting or held aborts with a jump-start flag.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         prescaler enable (freezes all tick-driven progress when low)
//   N          prescaler reload, tick period is N+1 enabled cycles
//   trigger    start request (level), accepted only in IDLE
//   react      driver button (level)
//   data_out   light bar
//   busy       high in LIGHTS, HOLD, TIMING
//   rt_valid   one-cycle pulse when rt_count is final
//   rt_count   reaction time in clk cycles, saturating
//   jump_start sticky jump-start flag, cleared by the next accepted trigger
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | lamps off, waiting for trigger
// LIGHTS | one more lamp per tick until all 8 are lit
// HOLD   | all lamps lit, counting down the random hold in ticks
// TIMING | lamps off, counting clk cycles until react
// DONE   | result held, waiting for react and trigger to both be low

module f1_start_ctrl #(
    parameter int WIDTH = 16,
    parameter int RT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] N,
    input  logic             trigger,
    input  logic             react,
    output logic [7:0]       data_out,
    output logic             busy,
    output logic             rt_valid,
    output logic [RT_W-1:0]  rt_count,
    output logic             jump_start
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LIGHTS = 3'd1;
    localparam logic [2:0] HOLD   = 3'd2;
    localparam logic [2:0] TIMING = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]       state;
    logic [WIDTH-1:0] pcnt;
    logic [6:0]       hold;
    logic [6:0]       lfsr;
    logic             tick;

    assign tick = en && (pcnt == '0);
    assign busy = (state == LIGHTS) || (state == HOLD) || (state == TIMING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            data_out   <= 8'h00;
            rt_valid   <= 1'b0;
            rt_count   <= '0;
            jump_start <= 1'b0;
            pcnt       <= '0;
            hold       <= 7'd0;
            lfsr       <= 7'h01;
        end else begin
            // Free-running so the hold length depends on when the trigger came.
            lfsr     <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            rt_valid <= 1'b0;

            // Parked at N outside the lamp sequence so the first lamp always
            // lands a full tick period after the trigger.
            if (state == IDLE || state == DONE) begin
                pcnt <= N;
            end else if (tick) begin
                pcnt <= N;
            end else if (en) begin
                pcnt <= pcnt - 1'b1;
            end

            case (state)
                IDLE: begin
                    data_out <= 8'h00;
                    if (trigger) begin
                        state      <= LIGHTS;
                        jump_start <= 1'b0;
                        rt_count   <= '0;
                    end
                end
                LIGHTS: begin
                    // A press before lights-out beats any tick on the same edge.
                    if (react) begin
                        state      <= IDLE;
                        data_out   <= 8'h00;
                        jump_start <= 1'b1;
                    end else if (tick) begin
                        if (data_out == 8'hFF) begin
                            state <= HOLD;
                            hold  <= lfsr;
                        end else begin
                            data_out <= {data_out[6:0], 1'b1};
                        end
                    end
                end
                HOLD: begin
                    if (react) begin
                        state      <= IDLE;
                        data_out   <= 8'h00;
                        jump_start <= 1'b1;
                    end else if (tick) begin
                        hold <= hold - 7'd1;
                        if (hold == 7'd1) begin
                            state    <= TIMING;
                            data_out <= 8'h00;
                            rt_count <= '0;
                        end
                    end
                end
                TIMING: begin
                    if (react) begin
                        state    <= DONE;
                        rt_valid <= 1'b1;
                    end else if (rt_count != '1) begin
                        rt_count <= rt_count + 1'b1;
                    end
                end
                DONE: begin
                    if (!react && !trigger) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    data_out <= 8'h00;
                end
            endcase
        end
    end

endmodule
